// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with edge-latched pending bits,
// a mask register and a two-state IDLE/SERVICE sequencer without nesting.
module irq_ctrl #(
    parameter int                NUM_IRQ    = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h00000018,
    parameter int                VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                stall,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic [ADDR_W-1:0]   pc_D,
    input  logic                rti,
    output logic                take,
    output logic [ADDR_W-1:0]   vector,
    output logic [ADDR_W-1:0]   epc,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  in_service,
    output logic                sr
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] win_oh;
    logic [3:0]         win_idx;
    logic [ADDR_W-1:0]  vec_calc;
    logic               armed;

    // The first cycle after reset only loads irq_q, so a line that was
    // already high while in reset is not mistaken for a fresh edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
            armed <= 1'b0;
        end else begin
            irq_q <= irq;
            armed <= 1'b1;
        end
    end

    assign rise     = irq & ~irq_q & {NUM_IRQ{armed}};
    assign eligible = pending & ~mask;

    always_comb begin
        win_idx = '0;
        win_oh  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx   = 4'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign vec_calc = VEC_BASE
                    + ADDR_W'(win_idx) * ADDR_W'(VEC_STRIDE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = SERVICE;
            SERVICE: if (rti)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sr     = (state == IDLE);
        take   = (|eligible) & sr & ~stall;
        vector = take ? vec_calc : '0;
    end

    // A new edge on the winner in the take cycle must survive the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(take ? win_oh : '0)) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc        <= '0;
            in_service <= '0;
        end else if (take) begin
            epc        <= pc_D;
            in_service <= win_oh;
        end else if (rti && state == SERVICE) begin
            in_service <= '0;
        end
    end

endmodule
